chimera_mem_arbiter: RTL
========================

CHIMERA_MEM_ARBITER -- requirements
Module: chimera_mem_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 4, number of requesters.
REQ-002 SHALL have parameter AddrWidth, default 32, request address width.
REQ-003 SHALL have parameter DataWidth, default 32, data width.
REQ-004 SHALL have parameter CntWidth, default 16, budget/period counter width.
REQ-005 SHALL have parameter MaxOutstanding, default 2, power of two, response-ID FIFO depth.
REQ-006 SHALL use a single clock; reset is synchronous and active-high.
REQ-007 SHALL have ports: clk_i in 1 clock; rst_i in 1 synchronous active-high reset.
REQ-008 SHALL have ports: req_i in NumReq request; gnt_o out NumReq grant; addr_i in NumReq*AddrWidth; we_i in NumReq write enable; wdata_i in NumReq*DataWidth.
REQ-009 SHALL have ports: rvalid_o out NumReq response valid; rdata_o out DataWidth response data, broadcast to all requesters.
REQ-010 SHALL have ports: mem_req_o out 1; mem_gnt_i in 1; mem_addr_o out AddrWidth; mem_we_o out 1; mem_wdata_o out DataWidth; mem_rvalid_i in 1; mem_rdata_i in DataWidth.
REQ-011 SHALL have ports: budget_i in NumReq*CntWidth, per-requester grants per period; period_i in CntWidth, period length in cycles; exhausted_o out NumReq, budget-empty flags.

Function
REQ-012 SHALL define a requester as eligible when req_i is high, its budget is nonzero (budget mode) and the ID FIFO is not full.
REQ-013 SHALL select one eligible requester round-robin, starting from the index after the last handshaken requester, wrapping from NumReq-1 to 0.
REQ-014 SHALL drive mem_req_o high combinationally whenever any requester is eligible, with mem_addr_o/mem_we_o/mem_wdata_o taken from the selected requester.
REQ-015 SHALL assert gnt_o of the selected requester only as mem_gnt_i AND mem_req_o, in the same cycle (zero-latency grant).
REQ-016 SHALL update the round-robin pointer only on a handshake (mem_req_o and mem_gnt_i).
REQ-017 SHALL keep the selection stable while mem_req_o is high without mem_gnt_i, unless the selected requester drops req_i.
REQ-018 SHALL push the granted index into the ID FIFO on every handshake.
REQ-019 SHALL pop the FIFO on mem_rvalid_i, asserting rvalid_o of the popped index in that cycle, with rdata_o = mem_rdata_i; responses SHALL arrive in order.
REQ-020 SHALL allow push and pop in the same cycle when the FIFO is full.
REQ-021 SHALL ignore mem_rvalid_i when the FIFO is empty, leaving all rvalid_o low.
REQ-022 SHALL run a period counter counting 0..period_i-1 and wrapping to 0; period_i = 0 SHALL behave as 1.
REQ-023 SHALL reload every budget counter from budget_i in each cycle the period counter is 0.
REQ-024 SHALL decrement a budget counter by one on each handshake of that requester, saturating at 0.
REQ-025 SHALL, for a reload and a handshake in the same cycle, load budget_i-1 (saturating at 0).
REQ-026 SHALL drive exhausted_o[i] high while budget counter i is 0.
REQ-027 SHALL never reorder, drop or duplicate requests or responses.

Reset
REQ-028 SHALL, while rst_i is high at a clock edge: clear the FIFO, set the pointer to 0, set the period counter to 0, and set the budget counters to 0.
REQ-029 SHALL hold all outputs low while rst_i is high, except exhausted_o, which SHALL be all ones.
REQ-030 SHALL perform the first budget reload in the first cycle after reset is released.
REQ-031 SHALL, on reset asserted mid-transaction, discard in-flight IDs and suppress the responses that follow them.

Configuration
REQ-032 SHALL, with CHIMERA_MEM_ARB_BUDGET_EN defined, implement REQ-012 budget gating and REQ-022..REQ-026 as specified.
REQ-033 SHALL, without CHIMERA_MEM_ARB_BUDGET_EN, omit the budget and period counters, ignore budget_i and period_i, tie exhausted_o to 0, and arbitrate plain round-robin.

Verification
REQ-034 SHALL cover: all four req_i held high, mem_gnt_i=1, budget off -> grants 0,1,2,3,0 on consecutive cycles.
REQ-035 SHALL cover: budget_i={1,1,1,1}, period_i=8, all requesting -> four grants, then no mem_req_o until cycle 8, where the budgets reload.
REQ-036 SHALL cover: MaxOutstanding=2 and mem_rvalid_i held low -> exactly two handshakes, then mem_req_o low until the first mem_rvalid_i.
REQ-037 SHALL cover: req 2 granted, mem_rvalid_i one cycle later with rdata 0xDEADBEEF -> rvalid_o=4'b0100 and rdata_o=0xDEADBEEF in that cycle.
REQ-038 SHALL cover: mem_gnt_i=0 for 3 cycles with req 1 pending -> gnt_o=0, mem_addr_o stable at addr_i[1], and the pointer unchanged.
REQ-039 SHALL cover: rst_i pulsed with 2 IDs outstanding -> the following mem_rvalid_i pulses produce no rvalid_o.

Source files
------------

// File: rtl/chimera_mem_arbiter.sv
// Round-robin arbiter from NumReq requesters onto one memory port, with in-order response routing.
// Define CHIMERA_MEM_ARB_BUDGET_EN to add per-requester grant budgets that reload once per period.
module chimera_mem_arbiter #(
  parameter int NumReq         = 4,
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 32,
  parameter int CntWidth       = 16,
  parameter int MaxOutstanding = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumReq-1:0]             req_i,
  output logic [NumReq-1:0]             gnt_o,
  input  logic [NumReq*AddrWidth-1:0]   addr_i,
  input  logic [NumReq-1:0]             we_i,
  input  logic [NumReq*DataWidth-1:0]   wdata_i,
  output logic [NumReq-1:0]             rvalid_o,
  output logic [DataWidth-1:0]          rdata_o,
  output logic                          mem_req_o,
  input  logic                          mem_gnt_i,
  output logic [AddrWidth-1:0]          mem_addr_o,
  output logic                          mem_we_o,
  output logic [DataWidth-1:0]          mem_wdata_o,
  input  logic                          mem_rvalid_i,
  input  logic [DataWidth-1:0]          mem_rdata_i,
  input  logic [NumReq*CntWidth-1:0]    budget_i,
  input  logic [CntWidth-1:0]           period_i,
  output logic [NumReq-1:0]             exhausted_o
);

  localparam int IW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int PW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CW = $clog2(MaxOutstanding) + 1;

  logic [IW-1:0]     ptr_q;
  logic [IW-1:0]     lock_idx_q;
  logic              lock_q;
  logic [IW-1:0]     fifo_q [2**PW];
  logic [PW-1:0]     wr_q;
  logic [PW-1:0]     rd_q;
  logic [CW-1:0]     cnt_q;

  logic              empty;
  logic              full;
  logic              pop;
  logic              space;
  logic [NumReq-1:0] budget_ok;
  logic [NumReq-1:0] elig;
  logic [IW-1:0]     sel;
  logic              any;
  logic              hs;
  int                j;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(MaxOutstanding));
  assign pop   = mem_rvalid_i & ~empty & ~rst_i;
  // A response leaving in this cycle frees the slot the new request needs.
  assign space = ~full | pop;
  assign elig  = req_i & budget_ok & {NumReq{space & ~rst_i}};

  always_comb begin
    sel = '0;
    any = 1'b0;
    j   = 0;
    if (lock_q && elig[lock_idx_q]) begin
      sel = lock_idx_q;
      any = 1'b1;
    end else begin
      for (int k = 0; k < NumReq; k++) begin
        j = int'(ptr_q) + k;
        if (j >= NumReq) j = j - NumReq;
        if (!any && elig[j]) begin
          sel = IW'(j);
          any = 1'b1;
        end
      end
    end
  end

  assign mem_req_o   = any;
  assign hs          = any & mem_gnt_i;
  assign mem_addr_o  = rst_i ? '0 : addr_i[int'(sel)*AddrWidth +: AddrWidth];
  assign mem_wdata_o = rst_i ? '0 : wdata_i[int'(sel)*DataWidth +: DataWidth];
  assign mem_we_o    = ~rst_i & we_i[sel];
  assign rdata_o     = rst_i ? '0 : mem_rdata_i;

  always_comb begin
    gnt_o = '0;
    if (hs) gnt_o[sel] = 1'b1;
  end

  always_comb begin
    rvalid_o = '0;
    if (pop) rvalid_o[fifo_q[rd_q]] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
    end else begin
      // Hold a stalled choice so later-arriving requesters cannot steal it.
      lock_q     <= any & ~mem_gnt_i;
      lock_idx_q <= sel;
      if (hs) begin
        fifo_q[wr_q] <= sel;
        wr_q         <= wr_q + PW'(1);
        ptr_q        <= (sel == IW'(NumReq - 1)) ? '0 : sel + IW'(1);
      end
      if (pop) rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_q + CW'(hs) - CW'(pop);
    end
  end

`ifdef CHIMERA_MEM_ARB_BUDGET_EN
  logic [CntWidth-1:0] pcnt_q;
  logic [CntWidth-1:0] plast;
  logic [CntWidth-1:0] bcnt_q [NumReq];
  logic [CntWidth-1:0] beff   [NumReq];
  logic                reload;

  assign plast  = (period_i == '0) ? '0 : period_i - CntWidth'(1);
  assign reload = (pcnt_q == '0);

  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      beff[i]        = reload ? budget_i[i*CntWidth +: CntWidth] : bcnt_q[i];
      budget_ok[i]   = (beff[i] != '0);
      exhausted_o[i] = rst_i | (bcnt_q[i] == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pcnt_q <= '0;
      for (int i = 0; i < NumReq; i++) bcnt_q[i] <= '0;
    end else begin
      pcnt_q <= (pcnt_q >= plast) ? '0 : pcnt_q + CntWidth'(1);
      for (int i = 0; i < NumReq; i++) begin
        if (hs && (int'(sel) == i) && (beff[i] != '0))
          bcnt_q[i] <= beff[i] - CntWidth'(1);
        else
          bcnt_q[i] <= beff[i];
      end
    end
  end
`else
  logic unused_budget;
  assign unused_budget = ^{budget_i, period_i};
  assign budget_ok     = '1;
  assign exhausted_o   = '0;
`endif

endmodule
